// File: rtl/pbi_pkg.sv
// Shared types and default widths for the peripheral bus initiator.
// Optional request timeout is enabled with the PBI_TIMEOUT_EN macro (see periph_bus_initiator).
package pbi_pkg;

    localparam int unsigned PBI_ADDR_W    = 24;
    localparam int unsigned PBI_DATA_W    = 32;
    localparam int unsigned PBI_STRB_W    = PBI_DATA_W / 8;
    localparam int unsigned PBI_CMD_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } pbi_state_e;

    typedef struct packed {
        logic [PBI_ADDR_W-1:0] addr;
        logic                  write;
        logic [PBI_DATA_W-1:0] wdata;
        logic [PBI_STRB_W-1:0] wstrb;
    } pbi_cmd_t;

endpackage

// File: rtl/pbi_cmd_fifo.sv
// Command FIFO for the bus initiator; pointers carry one extra wrap bit.
// Optional request timeout is enabled with the PBI_TIMEOUT_EN macro (see periph_bus_initiator).
module pbi_cmd_fifo
    import pbi_pkg::*;
#(
    parameter int unsigned DEPTH   = PBI_CMD_DEPTH,
    parameter type         entry_t = pbi_cmd_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            full_q, full_d;
    logic            empty_q;

    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        full_d = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    end

    // Full tracks the next pointers exactly so a push can never overflow.
    // Empty is sampled from the current pointers, so it lags a push by one cycle;
    // the consumer only pops after at least two non-idle cycles, so the lag is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= (wptr_q == rptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/periph_bus_initiator.sv
// Peripheral bus initiator: queues commands, issues them one at a time, returns responses.
// Define PBI_TIMEOUT_EN to abort requests that see no bus_ready within TIMEOUT_CYCLES.
module periph_bus_initiator
    import pbi_pkg::*;
#(
    parameter int unsigned ADDR_W    = PBI_ADDR_W,
    parameter int unsigned DATA_W    = PBI_DATA_W,
    parameter int unsigned CMD_DEPTH = PBI_CMD_DEPTH
`ifdef PBI_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                bus_valid,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_write,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ready,
    output logic                busy
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } cmd_t;

    cmd_t       push_cmd;
    cmd_t       head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_c;
    logic       pop_c;

    pbi_state_e        state_q;
    logic              bus_valid_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_write_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [STRB_W-1:0] bus_wstrb_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

`ifdef PBI_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] tmo_q;
`endif

    assign push_cmd = '{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata, wstrb: cmd_wstrb};
    assign push_c   = cmd_valid && !fifo_full;
    assign pop_c    = (state_q == IDLE) && !fifo_empty;

    pbi_cmd_fifo #(
        .DEPTH   (CMD_DEPTH),
        .entry_t (cmd_t)
    ) u_cmd_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (push_cmd),
        .pop   (pop_c),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Transaction sequencer: one outstanding request, response held until consumed.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_write_q <= 1'b0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef PBI_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_c) begin
                        bus_addr_q  <= head_cmd.addr;
                        bus_write_q <= head_cmd.write;
                        bus_wdata_q <= head_cmd.wdata;
                        bus_wstrb_q <= head_cmd.wstrb;
                        bus_valid_q <= 1'b1;
                        state_q     <= REQ;
`ifdef PBI_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= bus_write_q ? '0 : bus_rdata;
                        rsp_err_q   <= 1'b0;
                        state_q     <= RSP;
`ifdef PBI_TIMEOUT_EN
                    end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        bus_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RSP;
                    end else begin
                        tmo_q       <= tmo_q + TO_W'(1);
`endif
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    bus_valid_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = !fifo_full;
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_write = bus_write_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_periph_bus_initiator.sv
// Directed self-checking bench for periph_bus_initiator (default build; timeout case when PBI_TIMEOUT_EN).
module tb_periph_bus_initiator;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_valid;
    logic [23:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    periph_bus_initiator #(
        .ADDR_W    (24),
        .DATA_W    (32),
        .CMD_DEPTH (4)
`ifdef PBI_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .busy      (busy)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command and hold it until the edge that accepts it.
    task automatic push(input logic [23:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("push_timeout", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_bus_valid(input string tag);
        int n = 0;
        while (!bus_valid && n < 50) begin step(); n++; end
        chk(tag, 64'(bus_valid), 64'd1);
    endtask

    // Responder completes the current request; checks the held response.
    task automatic complete(input string tag, input logic [31:0] rd, input logic [31:0] exp_rd);
        bus_ready = 1'b1; bus_rdata = rd;
        step();
        bus_ready = 1'b0;
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        chk({tag, "_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_bus_drop"}, 64'(bus_valid), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_clr"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0; bus_rdata = '0; bus_ready = 1'b0;
        step(); step();
        chk("rst_bus_valid", 64'(bus_valid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();

        // Single read: accepted at edge N, bus_valid appears after N+2, ready on 3rd cycle.
        push(24'h000010, 1'b0, 32'h0, 4'h0);
        chk("rd_lat_n", 64'(bus_valid), 64'd0);
        step();
        chk("rd_lat_n1", 64'(bus_valid), 64'd0);
        step();
        chk("rd_lat_n2", 64'(bus_valid), 64'd1);
        chk("rd_addr", 64'(bus_addr), 64'h10);
        chk("rd_write", 64'(bus_write), 64'd0);
        chk("rd_busy", 64'(busy), 64'd1);
        step();
        chk("rd_hold1", 64'(bus_valid), 64'd1);
        step();
        chk("rd_hold2", 64'(bus_valid), 64'd1);
        complete("rd", 32'hA5A5_0001, 32'hA5A5_0001);
        chk("rd_idle_busy", 64'(busy), 64'd0);

        // Write: ready on the first request cycle, returned data must be zero.
        push(24'h000004, 1'b1, 32'hDEAD_BEEF, 4'hF);
        wait_bus_valid("wr_valid");
        chk("wr_addr", 64'(bus_addr), 64'h4);
        chk("wr_write", 64'(bus_write), 64'd1);
        chk("wr_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
        chk("wr_wstrb", 64'(bus_wstrb), 64'hF);
        complete("wr", 32'h1234_5678, 32'h0);

        // Five back-to-back pushes with the responder stalled; the first is popped
        // into REQ, so all five fit and the FIFO is full only after the fifth.
        cmd_write = 1'b0; cmd_wdata = '0; cmd_wstrb = '0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 24'h000100 + 24'(i);
            chk($sformatf("bp_ready_%0d", i), 64'(cmd_ready), 64'd1);
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_full", 64'(cmd_ready), 64'd0);
        chk("bp_first_req", 64'(bus_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            wait_bus_valid($sformatf("bp_valid_%0d", i));
            chk($sformatf("bp_addr_%0d", i), 64'(bus_addr), 64'h100 + 64'(i));
            step();
            chk($sformatf("bp_stable_%0d", i), 64'(bus_addr), 64'h100 + 64'(i));
            complete($sformatf("bp_%0d", i), 32'hC0DE_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
        end
        chk("bp_drained", 64'(busy), 64'd0);

        // Response held for 10 cycles while another command waits in the FIFO.
        push(24'h000020, 1'b0, 32'h0, 4'h0);
        wait_bus_valid("hold_valid");
        bus_ready = 1'b1; bus_rdata = 32'h5555_AAAA;
        step();
        bus_ready = 1'b0; bus_rdata = 32'h0;
        push(24'h000024, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_rv_%0d", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("hold_rd_%0d", i), 64'(rsp_rdata), 64'h5555_AAAA);
            chk($sformatf("hold_bv_%0d", i), 64'(bus_valid), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hold_rsp_clr", 64'(rsp_valid), 64'd0);
        chk("hold_gap", 64'(bus_valid), 64'd0);
        step();
        chk("hold_next_req", 64'(bus_valid), 64'd1);
        chk("hold_next_addr", 64'(bus_addr), 64'h24);

        // Reset while in REQ with two commands queued.
        push(24'h000030, 1'b0, 32'h0, 4'h0);
        push(24'h000034, 1'b0, 32'h0, 4'h0);
        chk("mid_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_bus_valid", 64'(bus_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        step(); step(); step();
        chk("mid_no_req", 64'(bus_valid), 64'd0);
        chk("mid_no_rsp", 64'(rsp_valid), 64'd0);

`ifdef PBI_TIMEOUT_EN
        // Responder never ready: request aborted after 8 cycles with an error.
        begin
            int n = 0;
            push(24'h000040, 1'b0, 32'h0, 4'h0);
            bus_rdata = 32'hFFFF_FFFF;
            wait_bus_valid("to_valid");
            while (bus_valid && n < 30) begin n++; step(); end
            chk("to_cycles", 64'(n), 64'd8);
            chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("to_err", 64'(rsp_err), 64'd1);
            chk("to_rdata", 64'(rsp_rdata), 64'd0);
            bus_ready = 1'b1;
            step();
            bus_ready = 1'b0;
            chk("to_late_err", 64'(rsp_err), 64'd1);
            chk("to_late_rdata", 64'(rsp_rdata), 64'd0);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            step(); step();
            chk("to_idle", 64'(bus_valid), 64'd0);
            chk("to_busy", 64'(busy), 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
